// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI bus arbiter.
package spi_pkg;

    // Arbiter FSM states; IDLE is the only state with busy low.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_HOLD     = 3'd4
    } spi_arbiter_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the setup/hold counter: must hold max(setup, hold) clocks.
    function automatic int cnt_width(input int setup_clks, input int hold_clks);
        return $clog2(max_int(setup_clks, hold_clks) + 1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module spi_rr_arbiter #(
    parameter int N = 4,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  request,
    input  logic [GW-1:0] last_grant,
    output logic          any,
    output logic [GW-1:0] grant_idx
);

    // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = last_grant;
        for (int off = N; off >= 1; off--) begin
            int idx;
            idx = (int'(last_grant) + off) % N;
            if (request[idx]) begin
                any       = 1'b1;
                grant_idx = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between several AXI-stream clients, one packet at a time,
// with a dedicated active-low chip select per client.
//
// Handshake rule on every stream: a word moves on a rising clk edge where tvalid and
// tready are both high; tvalid, once high, holds with stable data until that edge.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int TRANSFER_WIDTH = 8,
    parameter int CS_SETUP_CLKS  = 4,
    parameter int CS_HOLD_CLKS   = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQUESTERS-1:0]                  req_tvalid,
    input  logic [NUM_REQUESTERS*TRANSFER_WIDTH-1:0]   req_tdata,
    input  logic [NUM_REQUESTERS-1:0]                  req_tlast,
    output logic [NUM_REQUESTERS-1:0]                  req_tready,
    output logic [NUM_REQUESTERS-1:0]                  rsp_tvalid,
    output logic [TRANSFER_WIDTH-1:0]                  rsp_tdata,
    output logic                                       rsp_tlast,
    input  logic [NUM_REQUESTERS-1:0]                  rsp_tready,
    output logic                                       m_mosi_tvalid,
    output logic [TRANSFER_WIDTH-1:0]                  m_mosi_tdata,
    input  logic                                       m_mosi_tready,
    input  logic                                       m_miso_tvalid,
    input  logic [TRANSFER_WIDTH-1:0]                  m_miso_tdata,
    output logic                                       m_miso_tready,
    output logic [NUM_REQUESTERS-1:0]                  cs_n,
    output logic [$clog2(NUM_REQUESTERS)-1:0]          grant,
    output logic                                       busy,
    output spi_arbiter_state_t                         dbg_state
);

    localparam int N  = NUM_REQUESTERS;
    localparam int W  = TRANSFER_WIDTH;
    localparam int GW = $clog2(N);
    localparam int CW = cnt_width(CS_SETUP_CLKS, CS_HOLD_CLKS);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    spi_arbiter_state_t r_state;
    logic [N-1:0]       r_cs_n;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last_grant;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_last_q;

    logic               w_any;
    logic [GW-1:0]      w_pick;
    logic [W-1:0]       w_sel_data;
    logic               w_mosi_hs;
    logic               w_miso_hs;

    spi_rr_arbiter #(.N(N)) u_rr (
        .request    (req_tvalid),
        .last_grant (r_last_grant),
        .any        (w_any),
        .grant_idx  (w_pick)
    );

    assign w_sel_data = req_tdata[r_grant*W +: W];
    assign w_mosi_hs  = m_mosi_tvalid && m_mosi_tready;
    assign w_miso_hs  = m_miso_tvalid && m_miso_tready;

    // Packet sequencing: grant, CS setup delay, word ping-pong, CS hold delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cs_n       <= '1;
            r_grant      <= '0;
            r_last_grant <= GW'(N - 1);
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_last_q     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_cs_n  <= ~(ONE_HOT0 << w_pick);
                        r_cnt   <= CW'(CS_SETUP_CLKS - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) r_state <= ST_SEND;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                ST_SEND: begin
                    if (w_mosi_hs) begin
                        r_last_q <= req_tlast[r_grant];
                        r_state  <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (w_miso_hs) begin
                        if (r_last_q) begin
                            r_cnt   <= CW'(CS_HOLD_CLKS - 1);
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_cs_n       <= '1;
                        r_last_grant <= r_grant;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_cs_n  <= '1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency stream muxes: only the granted client is connected, only in its phase.
    always_comb begin
        m_mosi_tvalid = 1'b0;
        m_mosi_tdata  = '0;
        req_tready    = '0;
        m_miso_tready = 1'b0;
        rsp_tvalid    = '0;
        rsp_tdata     = '0;
        rsp_tlast     = 1'b0;
        if (r_state == ST_SEND) begin
            m_mosi_tvalid       = req_tvalid[r_grant];
            m_mosi_tdata        = w_sel_data;
            req_tready[r_grant] = m_mosi_tready;
        end
        if (r_state == ST_WAIT_RSP) begin
            rsp_tvalid[r_grant] = m_miso_tvalid;
            m_miso_tready       = rsp_tready[r_grant];
            rsp_tdata           = m_miso_tdata;
            rsp_tlast           = r_last_q;
        end
    end

    assign cs_n      = r_cs_n;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: a behavioural spi_master model answers each MOSI word with
// word ^ 8'h99 after a random delay; a scoreboard tracks expected MOSI and MISO words.
module tb_spi_arbiter;
    import spi_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SETUP = 4;
    localparam int HOLD  = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_tvalid;
    logic [N*W-1:0] req_tdata;
    logic [N-1:0]   req_tlast;
    logic [N-1:0]   req_tready;
    logic [N-1:0]   rsp_tvalid;
    logic [W-1:0]   rsp_tdata;
    logic           rsp_tlast;
    logic [N-1:0]   rsp_tready;
    logic           m_mosi_tvalid;
    logic [W-1:0]   m_mosi_tdata;
    logic           m_mosi_tready;
    logic           m_miso_tvalid;
    logic [W-1:0]   m_miso_tdata;
    logic           m_miso_tready;
    logic [N-1:0]   cs_n;
    logic [1:0]     grant;
    logic           busy;
    spi_arbiter_state_t dbg_state;

    spi_arbiter #(
        .NUM_REQUESTERS (N),
        .TRANSFER_WIDTH (W),
        .CS_SETUP_CLKS  (SETUP),
        .CS_HOLD_CLKS   (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_tvalid    (req_tvalid),
        .req_tdata     (req_tdata),
        .req_tlast     (req_tlast),
        .req_tready    (req_tready),
        .rsp_tvalid    (rsp_tvalid),
        .rsp_tdata     (rsp_tdata),
        .rsp_tlast     (rsp_tlast),
        .rsp_tready    (rsp_tready),
        .m_mosi_tvalid (m_mosi_tvalid),
        .m_mosi_tdata  (m_mosi_tdata),
        .m_mosi_tready (m_mosi_tready),
        .m_miso_tvalid (m_miso_tvalid),
        .m_miso_tdata  (m_miso_tdata),
        .m_miso_tready (m_miso_tready),
        .cs_n          (cs_n),
        .grant         (grant),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    logic outstanding = 1'b0;
    // entry = {client[1:0], last, data[7:0]}
    logic [10:0] exp_mosi_q[$];
    logic [10:0] exp_rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] d, input logic l);
        exp_mosi_q.push_back({c, l, d});
        exp_rsp_q.push_back({c, l, d ^ 8'h99});
    endtask

    function automatic logic cond_met(input int kind);
        case (kind)
            0: return cs_n != 4'hF;
            1: return cs_n == 4'hF;
            2: return m_mosi_tvalid;
            3: return ((rsp_tvalid & rsp_tready) != 0) && rsp_tlast;
            4: return (dbg_state == ST_SEND) && !outstanding;
            5: return m_miso_tvalid;
            6: return !busy && (exp_rsp_q.size() == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait; returns at the negedge where the condition first holds.
    task automatic wait_for(input string tag, input int kind);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cond_met(kind) && t < 300);
        check(tag, cond_met(kind), 1'b1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input int c, input int n, input logic [7:0] base, input logic last_end);
        int t;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            req_tvalid[c]        = 1'b1;
            req_tdata[c*W +: W]  = base + 8'(k);
            req_tlast[c]         = last_end && (k == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_tready[c] && t < 300);
            check("req_accept", req_tready[c], 1'b1);
            @(posedge clk); #1;
        end
        req_tvalid[c] = 1'b0;
        req_tlast[c]  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_mosi_q.delete();
        exp_rsp_q.delete();
    endtask

    // spi_master model: one word in flight, response = word ^ 8'h99 after 0..3 idle clocks.
    initial begin : master_model
        int ph;
        int dly;
        logic [7:0] cap;
        logic hs_mosi;
        logic hs_miso;
        logic [7:0] d;
        ph = 0; dly = 0; cap = '0;
        m_mosi_tready = 1'b1;
        m_miso_tvalid = 1'b0;
        m_miso_tdata  = '0;
        forever begin
            @(negedge clk);
            hs_mosi = m_mosi_tvalid && m_mosi_tready;
            hs_miso = m_miso_tvalid && m_miso_tready;
            d       = m_mosi_tdata;
            @(posedge clk); #1;
            if (reset) begin
                ph = 0;
                m_mosi_tready = 1'b1;
                m_miso_tvalid = 1'b0;
            end else if (ph == 0) begin
                if (hs_mosi) begin
                    m_mosi_tready = 1'b0;
                    cap = d;
                    dly = $urandom_range(0, 3);
                    ph  = 1;
                end
            end else if (ph == 1) begin
                if (dly == 0) begin
                    m_miso_tvalid = 1'b1;
                    m_miso_tdata  = cap ^ 8'h99;
                    ph = 2;
                end else begin
                    dly--;
                end
            end else begin
                if (hs_miso) begin
                    m_miso_tvalid = 1'b0;
                    m_mosi_tready = 1'b1;
                    ph = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [10:0] e;
        check("cs_onehot", ($countones(~cs_n) <= 1), 1'b1);
        check("busy_vs_cs", busy, (cs_n != 4'hF));
        check("ready_excl", req_tready & ~(4'b0001 << grant), 4'h0);
        if (outstanding) check("mosi_quiet", m_mosi_tvalid, 1'b0);
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (m_mosi_tvalid && m_mosi_tready) begin
                if (exp_mosi_q.size() == 0) begin
                    check("mosi_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_mosi_q.pop_front();
                    check("mosi_data", m_mosi_tdata, e[7:0]);
                    check("mosi_grant", grant, e[10:9]);
                end
                outstanding = 1'b1;
            end
            if ((rsp_tvalid & rsp_tready) != 0) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    check("rsp_valid", rsp_tvalid, 4'b0001 << e[10:9]);
                    check("rsp_data", rsp_tdata, e[7:0]);
                    check("rsp_last", rsp_tlast, e[8]);
                end
                rsp_cnt++;
                outstanding = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int c0;
        req_tvalid = '0;
        req_tdata  = '0;
        req_tlast  = '0;
        rsp_tready = '1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_grant", grant, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_req_tready", req_tready, 4'h0);
        check("rst_rsp_tvalid", rsp_tvalid, 4'h0);
        check("rst_mosi_tvalid", m_mosi_tvalid, 1'b0);
        check("rst_miso_tready", m_miso_tready, 1'b0);
        reset = 1'b0;

        // Single word from client 2
        push(2'd2, 8'hA5, 1'b1);
        fork send_pkt(2, 1, 8'hA5, 1'b1); join_none
        wait_for("t1_cs_fall", 0);
        t0 = cyc;
        check("t1_cs_n", cs_n, 4'b1011);
        check("t1_grant", grant, 2'd2);
        check("t1_busy", busy, 1'b1);
        wait_for("t1_mosi_valid", 2);
        check("t1_setup_clks", cyc - t0, SETUP);
        check("t1_mosi_data", m_mosi_tdata, 8'hA5);
        wait_for("t1_rsp_last", 3);
        t0 = cyc;
        check("t1_rsp_data", rsp_tdata, 8'h3C);
        check("t1_rsp_client", rsp_tvalid, 4'b0100);
        wait_for("t1_cs_rise", 1);
        check("t1_hold_clks", cyc - t0, HOLD + 1);
        wait fork;

        // Round-robin between clients 0 and 3 from reset priority
        apply_reset();
        push(2'd0, 8'h10, 1'b1);
        push(2'd3, 8'h31, 1'b1);
        push(2'd0, 8'h11, 1'b1);
        push(2'd3, 8'h32, 1'b1);
        fork
            begin send_pkt(0, 1, 8'h10, 1'b1); send_pkt(0, 1, 8'h11, 1'b1); end
            begin send_pkt(3, 1, 8'h31, 1'b1); send_pkt(3, 1, 8'h32, 1'b1); end
        join
        wait_for("t2_drain", 6);

        // Multi-word packet from client 1 in one chip-select window
        push(2'd1, 8'h01, 1'b0);
        push(2'd1, 8'h02, 1'b0);
        push(2'd1, 8'h03, 1'b1);
        fork send_pkt(1, 3, 8'h01, 1'b1); join_none
        wait_for("t3_cs_fall", 0);
        check("t3_cs_n", cs_n, 4'b1101);
        c0 = rsp_cnt;
        wait_for("t3_cs_rise", 1);
        check("t3_words_in_cs", rsp_cnt - c0, 3);
        wait fork;

        // Response backpressure on client 0
        @(posedge clk); #1;
        rsp_tready[0] = 1'b0;
        push(2'd0, 8'h5A, 1'b1);
        fork send_pkt(0, 1, 8'h5A, 1'b1); join_none
        wait_for("t4_miso_valid", 5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_miso_tready", m_miso_tready, 1'b0);
            check("t4_state", dbg_state, ST_WAIT_RSP);
        end
        check("t4_held_data", rsp_tdata, 8'hC3);
        @(posedge clk); #1;
        rsp_tready[0] = 1'b1;
        wait_for("t4_drain", 6);
        wait fork;

        // Reset while stalled in SEND before word 2 of a packet
        push(2'd1, 8'h11, 1'b0);
        fork send_pkt(1, 1, 8'h11, 1'b0); join_none
        wait fork;
        wait_for("t5_stall_send", 4);
        #1;
        reset = 1'b1;
        #1;
        check("t5_cs_async", cs_n, 4'hF);
        check("t5_busy_async", busy, 1'b0);
        check("t5_state_async", dbg_state, ST_IDLE);
        check("t5_mosi_async", m_mosi_tvalid, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_mosi_q.delete();
        exp_rsp_q.delete();
        push(2'd0, 8'hC0, 1'b1);
        push(2'd3, 8'h30, 1'b1);
        fork
            send_pkt(0, 1, 8'hC0, 1'b1);
            send_pkt(3, 1, 8'h30, 1'b1);
        join
        wait_for("t5_drain", 6);

        // New request arriving in the last HOLD cycle
        push(2'd2, 8'h66, 1'b1);
        push(2'd1, 8'h77, 1'b1);
        fork send_pkt(2, 1, 8'h66, 1'b1); join_none
        wait_for("t6_rsp_last", 3);
        fork
            begin
                repeat (3) @(posedge clk);
                send_pkt(1, 1, 8'h77, 1'b1);
            end
        join_none
        repeat (4) @(negedge clk);
        check("t6_last_hold_cs", cs_n, 4'b1011);
        @(negedge clk);
        check("t6_idle_cs", cs_n, 4'hF);
        check("t6_idle_busy", busy, 1'b0);
        @(negedge clk);
        check("t6_new_cs", cs_n, 4'b1101);
        check("t6_new_grant", grant, 2'd1);
        wait fork;
        wait_for("t6_drain", 6);

        check("mosi_q_empty", exp_mosi_q.size(), 0);
        check("rsp_q_empty", exp_rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
